// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory request, fills the IF/ID register,
// parks a fetched word while ID stalls, and drains stale transfers after a redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic        if_stop,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            id_pc_q     <= 32'h0;
            id_instr_q  <= NOP_INSTR;
            id_valid_q  <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= 32'h0;
            drop_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            id_valid_q  <= id_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        id_valid_d  = id_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        drop_addr_d = drop_addr_q;
        if_stop     = 1'b0;

        case (state_q)
            RUN: begin
                if_stop = stall | ~imem_ready;
                if (redirect) begin
                    pc_d       = npc;
                    id_valid_d = 1'b0;
                    // A transfer already on the bus must complete before the new target is issued.
                    if (!imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        id_pc_d    = pc_q;
                        id_instr_d = imem_rdata;
                        id_valid_d = 1'b1;
                        pc_d       = npc;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if_stop = stall;
                if (redirect) begin
                    pc_d       = npc;
                    id_valid_d = 1'b0;
                    state_d    = RUN;
                end else if (!stall) begin
                    id_pc_d    = buf_pc_q;
                    id_instr_d = buf_instr_q;
                    id_valid_d = 1'b1;
                    pc_d       = npc;
                    state_d    = RUN;
                end
            end
            DROP: begin
                if_stop = 1'b1;
                if (redirect) begin
                    pc_d = npc;
                end
                if (!stall || redirect) begin
                    id_valid_d = 1'b0;
                end
                if (imem_ready) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Gating with rst_n keeps the request low for the whole reset interval.
    assign imem_req  = rst_n & (state_q != HOLD);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign if_pc     = pc_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_valid_q ? id_instr_q : NOP_INSTR;
    assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the fetch pipeline.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = 32'h0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_pc;
    logic        if_stop;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: a fetch address, an optional outstanding stale transfer,
    // a queue of parked fetched words and the IF/ID contents.
    logic [31:0] m_pc;
    logic        m_dropping;
    logic [31:0] m_drop_addr;
    logic [63:0] m_buf[$];
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    logic        m_id_valid;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .redirect   (redirect),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_stop    (if_stop),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_valid   (id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h9BDF};
    endfunction

    function automatic logic exp_req();
        return m_buf.size() == 0;
    endfunction

    function automatic logic [31:0] exp_addr();
        return m_dropping ? m_drop_addr : m_pc;
    endfunction

    function automatic logic exp_stop();
        if (m_dropping) return 1'b1;
        if (m_buf.size() != 0) return stall;
        return stall | ~imem_ready;
    endfunction

    function automatic logic [31:0] exp_instr();
        return m_id_valid ? m_id_instr : NOP;
    endfunction

    task automatic model_reset();
        m_pc        = 32'h0;
        m_dropping  = 1'b0;
        m_drop_addr = 32'h0;
        m_buf.delete();
        m_id_pc     = 32'h0;
        m_id_instr  = NOP;
        m_id_valid  = 1'b0;
    endtask

    // Drive one cycle's inputs; the next-PC unit is emulated from the model's own PC.
    task automatic apply(input logic r, input logic [31:0] tgt, input logic s, input logic rdy);
        redirect   = r;
        stall      = s;
        imem_ready = rdy;
        imem_rdata = mem_word(exp_addr());
        npc        = r ? tgt : (exp_stop() ? m_pc : m_pc + 32'd4);
        #1;
    endtask

    task automatic tick();
        logic [31:0] old_pc;
        @(posedge clk);
        if (rst_n) begin
            old_pc = m_pc;
            if (m_dropping) begin
                if (redirect) m_pc = npc;
                if (!stall || redirect) m_id_valid = 1'b0;
                if (imem_ready) m_dropping = 1'b0;
            end else if (m_buf.size() != 0) begin
                if (redirect) begin
                    m_buf.delete();
                    m_pc = npc;
                    m_id_valid = 1'b0;
                end else if (!stall) begin
                    {m_id_pc, m_id_instr} = m_buf.pop_front();
                    m_id_valid = 1'b1;
                    m_pc = npc;
                end
            end else if (redirect) begin
                m_pc = npc;
                m_id_valid = 1'b0;
                if (!imem_ready) begin
                    m_dropping  = 1'b1;
                    m_drop_addr = old_pc;
                end
            end else if (imem_ready) begin
                if (!stall) begin
                    m_id_pc    = old_pc;
                    m_id_instr = imem_rdata;
                    m_id_valid = 1'b1;
                    m_pc       = npc;
                end else begin
                    m_buf.push_back({old_pc, imem_rdata});
                end
            end else if (!stall) begin
                m_id_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || if_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h id_pc=%h if_pc=%h, want 0 0 %h 0 0",
                     imem_req, id_valid, id_instr, id_pc, if_pc, NOP);
        end
        model_reset();
        rst_n = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if (imem_addr !== 32'(4 * i) || if_stop !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_addr%0d: addr=%h stop=%b, want %h 0", i, imem_addr, if_stop, 4 * i);
            end
            tick();
            vectors++;
            if (id_pc !== 32'(4 * i) || id_valid !== 1'b1 || id_instr !== mem_word(32'(4 * i))) begin
                miscompares++;
                $display("FAIL seq_id%0d: id_pc=%h valid=%b instr=%h, want %h 1 %h",
                         i, id_pc, id_valid, id_instr, 4 * i, mem_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (if_stop !== 1'b1 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                miscompares++;
                $display("FAIL wait_hold%0d: stop=%b addr=%h req=%b, want 1 00000010 1", i, if_stop, imem_addr, imem_req);
            end
            tick();
            vectors++;
            if (id_valid !== 1'b0 || id_instr !== NOP) begin
                miscompares++;
                $display("FAIL wait_bubble%0d: valid=%b instr=%h, want 0 %h", i, id_valid, id_instr, NOP);
            end
        end
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        vectors++;
        if (id_pc !== 32'h10 || id_valid !== 1'b1 || if_pc !== 32'h14) begin
            miscompares++;
            $display("FAIL wait_latch: id_pc=%h valid=%b if_pc=%h, want 00000010 1 00000014", id_pc, id_valid, if_pc);
        end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b1);
            tick();
        end
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 32'h0, 1'b1, 1'b1);
            vectors++;
            if (imem_req !== 1'b0 || if_stop !== 1'b1 || id_pc !== 32'h1C) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: req=%b stop=%b id_pc=%h, want 0 1 0000001c", i, imem_req, if_stop, id_pc);
            end
            tick();
        end
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (id_pc !== 32'h20 || id_valid !== 1'b1 || id_instr !== mem_word(32'h20) || imem_addr !== 32'h24 || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: id_pc=%h valid=%b instr=%h addr=%h req=%b, want 00000020 1 %h 00000024 1",
                     id_pc, id_valid, id_instr, imem_addr, imem_req, mem_word(32'h20));
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] held_id_pc;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b1);
            tick();
        end
        held_id_pc = m_id_pc;
        apply(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h30 || if_stop !== 1'b1 || id_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL drop_wait%0d: req=%b addr=%h stop=%b valid=%b, want 1 00000030 1 0",
                         i, imem_req, imem_addr, if_stop, id_valid);
            end
            tick();
        end
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (imem_addr !== 32'h100 || id_valid !== 1'b0 || id_pc !== held_id_pc) begin
            miscompares++;
            $display("FAIL drop_done: addr=%h valid=%b id_pc=%h, want 00000100 0 %h", imem_addr, id_valid, id_pc, held_id_pc);
        end
    endtask

    task automatic test_redirect_stall();
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        apply(1'b1, 32'h200, 1'b1, 1'b1);
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
            miscompares++;
            $display("FAIL flush_pre: valid=%b id_pc=%h, want 1 00000100", id_valid, id_pc);
        end
        tick();
        vectors++;
        if (id_valid !== 1'b0 || if_pc !== 32'h200 || id_instr !== NOP) begin
            miscompares++;
            $display("FAIL flush_stall: valid=%b if_pc=%h instr=%h, want 0 00000200 %h", id_valid, if_pc, id_instr, NOP);
        end
    endtask

    task automatic test_wrap();
        apply(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b1);
            tick();
        end
        vectors++;
        if (if_pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pc_wrap: if_pc=%h id_pc=%h valid=%b, want 00000000 fffffffc 1", if_pc, id_pc, id_valid);
        end
    endtask

    task automatic test_reset_in_drop();
        apply(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (if_pc !== 32'h0 || id_valid !== 1'b0 || imem_req !== 1'b0 || id_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: if_pc=%h valid=%b req=%b id_pc=%h, want 0 0 0 0", if_pc, id_valid, imem_req, id_pc);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (if_stop !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_to_run: stop=%b req=%b addr=%h, want 0 1 00000000", if_stop, imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_random();
        logic r, s, rdy;
        logic [31:0] tgt;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 9) < 3);
            rdy = ($urandom_range(0, 9) < 6);
            tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            apply(r, tgt, s, rdy);
            vectors++;
            if (imem_req !== exp_req() || (exp_req() && imem_addr !== exp_addr()) || if_pc !== m_pc ||
                if_stop !== exp_stop() || id_pc !== m_id_pc || id_valid !== m_id_valid || id_instr !== exp_instr()) begin
                miscompares++;
                $display("FAIL random%0d: req=%b addr=%h pc=%h stop=%b id=%h/%b/%h, want %b %h %h %b %h/%b/%h",
                         i, imem_req, imem_addr, if_pc, if_stop, id_pc, id_valid, id_instr,
                         exp_req(), exp_addr(), m_pc, exp_stop(), m_id_pc, m_id_valid, exp_instr());
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_hold();
        test_redirect_drop();
        test_redirect_stall();
        test_wrap();
        test_reset_in_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
